// File: rtl/bm_tile_pkg.sv
// Shared tile, random-code and FSM types for the map filler.
// Also holds the code-to-tile map as a function.
package bm_tile_pkg;

  typedef enum logic [2:0] {
    EMPTY        = 3'd0,
    HARD         = 3'd1,
    SOFT         = 3'd2,
    SOFT_BOMBUP  = 3'd3,
    SOFT_FLAMEUP = 3'd4
  } tile_t;

  localparam logic [3:0] RND_EMPTY_A = 4'd2;
  localparam logic [3:0] RND_SOFT    = 4'd4;
  localparam logic [3:0] RND_BOMBUP  = 4'd8;
  localparam logic [3:0] RND_FLAMEUP = 4'd6;
  localparam logic [3:0] RND_EMPTY_B = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    CELL,
    WAIT_RND,
    DONE
  } state_t;

  function automatic tile_t code_to_tile(
    input logic [3:0] code
  );
    unique case (code)
      RND_SOFT:    return SOFT;
      RND_BOMBUP:  return SOFT_BOMBUP;
      RND_FLAMEUP: return SOFT_FLAMEUP;
      RND_EMPTY_A: return EMPTY;
      RND_EMPTY_B: return EMPTY;
      default:     return EMPTY;
    endcase
  endfunction

  function automatic logic is_soft(
    input tile_t t
  );
    return (t == SOFT) ||
           (t == SOFT_BOMBUP) ||
           (t == SOFT_FLAMEUP);
  endfunction

endpackage

// File: rtl/tile_classify.sv
// Fixed-geometry classifier for one grid cell.
// Hard walls: border and even/even pillars; spawn: corner Ls.
module tile_classify #(
  parameter int ROWS = 13,
  parameter int COLS = 15,
  parameter int RW   = 4,
  parameter int CW   = 4
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic          is_hard,
  output logic          is_spawn
);

  localparam logic [RW-1:0] R1  = RW'(1);
  localparam logic [RW-1:0] R2  = RW'(2);
  localparam logic [RW-1:0] RL  = RW'(ROWS - 1);
  localparam logic [RW-1:0] RL1 = RW'(ROWS - 2);
  localparam logic [RW-1:0] RL2 = RW'(ROWS - 3);
  localparam logic [CW-1:0] C1  = CW'(1);
  localparam logic [CW-1:0] C2  = CW'(2);
  localparam logic [CW-1:0] CL  = CW'(COLS - 1);
  localparam logic [CW-1:0] CL1 = CW'(COLS - 2);
  localparam logic [CW-1:0] CL2 = CW'(COLS - 3);

  logic c_edge;
  logic c_near;

  // Columns touching a corner L: adjacent (near) or one further.
  assign c_edge = (col == C1) || (col == CL1);
  assign c_near = c_edge || (col == C2) || (col == CL2);

  // Border and pillar walls, then the four corner Ls.
  always_comb begin
    is_hard = (row == '0) || (row == RL) ||
              (col == '0) || (col == CL) ||
              (!row[0] && !col[0]);
    is_spawn = ((row == R1) && c_near) ||
               ((row == R2) && c_edge) ||
               ((row == RL1) && c_near) ||
               ((row == RL2) && c_edge);
  end

endmodule

// File: rtl/rnd_map_filler.sv
// Rasters the play grid, drawing one random code per open cell.
// Writes are registered one cycle after the cell is resolved.
module rnd_map_filler
  import bm_tile_pkg::*;
#(
  parameter int COLS   = 15,
  parameter int ROWS   = 13,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        soft_count,
  input  logic              rnd_valid,
  input  logic [3:0]        rnd_data,
  output logic              rnd_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  state_t            state;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ADDR_W-1:0] addr;
  logic              is_hard;
  logic              is_spawn;
  logic              take;
  logic              last;
  tile_t             tile;

  tile_classify #(
    .ROWS(ROWS),
    .COLS(COLS),
    .RW  (RW),
    .CW  (CW)
  ) u_cls (
    .row     (row),
    .col     (col),
    .is_hard (is_hard),
    .is_spawn(is_spawn)
  );

  assign rnd_ready = (state == WAIT_RND);
  assign last = (row == RW'(ROWS - 1)) &&
                (col == CW'(COLS - 1));

  // Resolve the current cell: fixed in CELL, coded on handshake.
  always_comb begin
    take = 1'b0;
    tile = EMPTY;
    unique case (state)
      CELL: begin
        take = is_hard || is_spawn;
        tile = is_hard ? HARD : EMPTY;
      end
      WAIT_RND: begin
        take = rnd_valid;
        tile = code_to_tile(rnd_data);
      end
      default: ;
    endcase
  end

  // Fill sequencer with registered write port and status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      soft_count <= '0;
      row        <= '0;
      col        <= '0;
      addr       <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (take) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= tile;
        if (is_soft(tile))
          soft_count <= soft_count + 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= CELL;
            busy       <= 1'b1;
            row        <= '0;
            col        <= '0;
            addr       <= '0;
            soft_count <= '0;
          end
        end
        CELL, WAIT_RND: begin
          if (take) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CELL;
              addr  <= addr + ADDR_W'(1);
              if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end else if (state == CELL) begin
            state <= WAIT_RND;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
